voice_tick_sched: RTL and testbench

VOICE_TICK_SCHED -- requirements
Module: voice_tick_sched

---
 rtl/voice_tick_sched.sv | 174 +++++++++++++++++
 tb/tb_voice_tick_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_tick_sched.sv
// voice_tick_sched: programmable sample-tick divider driving a per-frame
// voice issue sequencer (one start strobe per active voice, then a mix strobe).
//
// state | meaning
// IDLE  | waiting for sample_tick to start a frame
// ISSUE | strobe voice_en for idx, arm the wait timer
// WAIT  | wait for voice_done[idx] or wait-timer expiry
// MIX   | strobe mix_en, frame complete
module voice_tick_sched #(
  parameter int unsigned IN_FREQ    = 50000000,
  parameter int unsigned OUT_FREQ   = 48000,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [26:0]           cfg_div,
  input  logic                  cfg_load,
  input  logic [NUM_VOICES-1:0] voice_active,
  input  logic [NUM_VOICES-1:0] voice_done,
  input  logic                  err_clr,
  output logic                  sample_tick,
  output logic [NUM_VOICES-1:0] voice_en,
  output logic                  mix_en,
  output logic                  busy,
  output logic                  overrun,
  output logic [NUM_VOICES-1:0] timeout_err
);

  // A ratio below 2 would give a zero divider; clamp so the reset period is sane.
  localparam int unsigned RATIO = (IN_FREQ / OUT_FREQ >= 2) ? IN_FREQ / OUT_FREQ : 2;
  localparam logic [26:0] DIV_RST = 27'(RATIO - 1);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned TMO = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int TW = $clog2(TMO + 1);
  // Wait timer counts down from TMO-1 so expiry lands on the TMO-th WAIT cycle.
  localparam logic [TW-1:0] TMO_LOAD = TW'(TMO - 1);
  localparam logic [NUM_VOICES-1:0] ONE = NUM_VOICES'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_MIX} state_t;

  logic [26:0]           cnt_q, cnt_d, div_q, div_d;
  logic                  tick_q, tick_d;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_VOICES-1:0] mask_q, mask_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [NUM_VOICES-1:0] voice_en_q, voice_en_d;
  logic                  mix_en_q, mix_en_d;
  logic                  overrun_q, overrun_d;
  logic [NUM_VOICES-1:0] tmo_err_q, tmo_err_d;
  logic [IW:0]           first_set, next_above;
  logic                  advance;

  // Lowest set bit of m at or above start; MSB of the result is the found flag.
  function automatic logic [IW:0] next_set(input logic [NUM_VOICES-1:0] m, input int start);
    logic [IW:0] r;
    r = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (m[i] && i >= start) r = {1'b1, IW'(i)};
    end
    return r;
  endfunction

  // Divider: wrap on terminal count, cfg_load restarts the period without a tick.
  always_comb begin
    cnt_d  = cnt_q + 27'd1;
    div_d  = div_q;
    tick_d = 1'b0;
    if (cfg_load) begin
      div_d = (cfg_div == 27'd0) ? 27'd1 : cfg_div;
      cnt_d = '0;
    end else if (cnt_q == div_q) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Frame sequencer next-state, strobes and sticky error flags.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    tmr_d      = tmr_q;
    voice_en_d = '0;
    mix_en_d   = 1'b0;
    advance    = 1'b0;
    overrun_d  = err_clr ? 1'b0 : overrun_q;
    tmo_err_d  = err_clr ? '0 : tmo_err_q;
    first_set  = next_set(voice_active, 0);
    next_above = next_set(mask_q, int'(idx_q) + 1);

    if (tick_q && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick_q) begin
          mask_d = voice_active;
          if (first_set[IW]) begin
            idx_d   = first_set[IW-1:0];
            state_d = S_ISSUE;
          end else begin
            state_d = S_MIX;
          end
        end
      end
      S_ISSUE: begin
        voice_en_d = ONE << idx_q;
        tmr_d      = TMO_LOAD;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (voice_done[idx_q]) begin
          advance = 1'b1;
        end else if (tmr_q == '0) begin
          advance   = 1'b1;
          tmo_err_d = tmo_err_d | (ONE << idx_q);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
        if (advance) begin
          if (next_above[IW]) begin
            idx_d   = next_above[IW-1:0];
            state_d = S_ISSUE;
          end else begin
            state_d = S_MIX;
          end
        end
      end
      S_MIX: begin
        mix_en_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= DIV_RST;
      tick_q     <= 1'b0;
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mask_q     <= '0;
      tmr_q      <= '0;
      voice_en_q <= '0;
      mix_en_q   <= 1'b0;
      overrun_q  <= 1'b0;
      tmo_err_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      tmr_q      <= tmr_d;
      voice_en_q <= voice_en_d;
      mix_en_q   <= mix_en_d;
      overrun_q  <= overrun_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign sample_tick = tick_q;
  assign voice_en    = voice_en_q;
  assign mix_en      = mix_en_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_voice_tick_sched.sv
// Directed bench for voice_tick_sched: divider, frame sequencing, timeouts,
// overrun, runtime divider reload and reset abort.
module tb_voice_tick_sched;

  logic        clk = 1'b0;
  logic        rst, cfg_load, err_clr;
  logic [26:0] cfg_div;
  logic [3:0]  voice_active, voice_done;
  logic        sample_tick, mix_en, busy, overrun;
  logic [3:0]  voice_en, timeout_err;

  always #5 clk = ~clk;

  voice_tick_sched #(
    .IN_FREQ(1000), .OUT_FREQ(100), .NUM_VOICES(4), .TIMEOUT(5)
  ) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_load(cfg_load),
    .voice_active(voice_active), .voice_done(voice_done), .err_clr(err_clr),
    .sample_tick(sample_tick), .voice_en(voice_en), .mix_en(mix_en),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  mask;
    int          delay;
    int          wh;     // voice whose done is withheld (-1: none)
    int          n;
    logic [15:0] seq;    // voice_en strobes, first in [3:0]
    logic [3:0]  tmo;
    logic        ovr;
  } frame_vec_t;

  typedef struct {
    logic [26:0] div;
    int          period;
  } div_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      step();
      n++;
      if (sample_tick) ok = 1'b1;
    end
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  // Starts on the next idle tick, answers each voice_en after 'delay' cycles
  // (wrong-voice done for the withheld voice), stops on mix_en.
  task automatic run_frame(input logic [3:0] mask, input int delay, input int wh,
                           input bit hold_clr, input bit do_load,
                           output int n, output logic [15:0] seq, output logic busy_at_mix,
                           output int tmo_off, output logic [3:0] tmo_first, output bit ok);
    int         cyc, pend, wv;
    logic [3:0] pend_v;
    bit         started, got_mix;
    n = 0; seq = '0; busy_at_mix = 1'b1; tmo_off = -1; tmo_first = '0; ok = 1'b0;
    pend = 0; pend_v = '0; wv = -1; started = 1'b0; got_mix = 1'b0; cyc = 0;
    voice_active = mask;
    while (!started && cyc < 50) begin
      step();
      cyc++;
      if (sample_tick && !busy) started = 1'b1;
    end
    if (started) begin
      if (hold_clr) err_clr = 1'b1;
      cyc = 0;
      while (!got_mix && cyc < 300) begin
        step();
        cyc++;
        cfg_load   = 1'b0;
        voice_done = '0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) voice_done = pend_v;
        end
        if (wv >= 0) begin
          wv++;
          if (tmo_off < 0 && timeout_err != 4'd0) begin
            tmo_off   = wv;
            tmo_first = timeout_err;
          end
        end
        if (voice_en != 4'd0) begin
          if (n < 4) seq[n*4 +: 4] = voice_en;
          n++;
          if (n == 1) begin
            voice_active = ~mask;
            if (do_load) begin
              cfg_div  = 27'd3;
              cfg_load = 1'b1;
            end
          end
          pend = delay;
          if (wh >= 0 && voice_en[wh]) begin
            pend_v = ~voice_en;
            wv     = 0;
          end else begin
            pend_v = voice_en;
          end
        end
        if (mix_en) begin
          got_mix     = 1'b1;
          busy_at_mix = busy;
        end
      end
    end
    voice_done   = '0;
    err_clr      = 1'b0;
    cfg_load     = 1'b0;
    voice_active = '0;
    ok = got_mix;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "aborting");
  end

  initial begin
    frame_vec_t  fv[6];
    div_vec_t    dv[5];
    int          n, k, toff, p, mixes;
    bit          ok, ok2;
    logic [15:0] seq;
    logic        bam;
    logic [3:0]  tfirst;

    fv[0] = '{mask: 4'b1011, delay: 3, wh: -1, n: 3, seq: 16'h0821, tmo: 4'b0000, ovr: 1'b1};
    fv[1] = '{mask: 4'b0100, delay: 1, wh: -1, n: 1, seq: 16'h0004, tmo: 4'b0000, ovr: 1'b0};
    fv[2] = '{mask: 4'b1111, delay: 4, wh: -1, n: 4, seq: 16'h8421, tmo: 4'b0000, ovr: 1'b1};
    fv[3] = '{mask: 4'b1000, delay: 2, wh: -1, n: 1, seq: 16'h0008, tmo: 4'b0000, ovr: 1'b0};
    fv[4] = '{mask: 4'b1011, delay: 3, wh: 1,  n: 3, seq: 16'h0821, tmo: 4'b0010, ovr: 1'b1};
    fv[5] = '{mask: 4'b0110, delay: 3, wh: 2,  n: 2, seq: 16'h0042, tmo: 4'b0100, ovr: 1'b1};

    dv[0] = '{div: 27'd0,  period: 2};
    dv[1] = '{div: 27'd1,  period: 2};
    dv[2] = '{div: 27'd5,  period: 6};
    dv[3] = '{div: 27'd3,  period: 4};
    dv[4] = '{div: 27'd20, period: 21};

    rst = 1'b1; cfg_load = 1'b0; cfg_div = '0; err_clr = 1'b0;
    voice_active = '0; voice_done = '0;
    repeat (3) step();
    chk("rst_sample_tick", 32'(sample_tick), 32'd0);
    chk("rst_voice_en",    32'(voice_en),    32'd0);
    chk("rst_mix_en",      32'(mix_en),      32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
    chk("rst_overrun",     32'(overrun),     32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    rst = 1'b0;
    wait_tick(n, ok);
    chk("first_tick_seen", 32'(ok), 32'd1);
    chk("first_tick_latency", 32'(n), 32'd10);
    wait_tick(n, ok);
    chk("tick_period_reset_div", 32'(n), 32'd10);

    // empty frame started by that tick; stray done bits must be ignored
    voice_done = 4'hF;
    step();
    chk("empty_busy", 32'(busy), 32'd1);
    chk("empty_no_voice_en_a", 32'(voice_en), 32'd0);
    step();
    chk("empty_mix_en", 32'(mix_en), 32'd1);
    chk("empty_no_voice_en_b", 32'(voice_en), 32'd0);
    chk("empty_idle_after", 32'(busy), 32'd0);
    voice_done = '0;
    step();
    chk("empty_mix_one_cycle", 32'(mix_en), 32'd0);
    chk("empty_no_overrun", 32'(overrun), 32'd0);

    for (int i = 0; i < 6; i++) begin
      clear_errs();
      run_frame(fv[i].mask, fv[i].delay, fv[i].wh, 1'b0, 1'b0, n, seq, bam, toff, tfirst, ok);
      chk($sformatf("frame%0d_done", i), 32'(ok), 32'd1);
      chk($sformatf("frame%0d_count", i), 32'(n), 32'(fv[i].n));
      chk($sformatf("frame%0d_seq", i), 32'(seq), 32'(fv[i].seq));
      chk($sformatf("frame%0d_busy_at_mix", i), 32'(bam), 32'd0);
      chk($sformatf("frame%0d_timeout_err", i), 32'(timeout_err), 32'(fv[i].tmo));
      chk($sformatf("frame%0d_overrun", i), 32'(overrun), 32'(fv[i].ovr));
      if (fv[i].wh >= 0) chk($sformatf("frame%0d_tmo_latency", i), 32'(toff), 32'd5);
    end

    // timeout flag set while err_clr is held: set wins, then clears
    clear_errs();
    run_frame(4'b1011, 3, 1, 1'b1, 1'b0, n, seq, bam, toff, tfirst, ok);
    chk("tmo_hold_done", 32'(ok), 32'd1);
    chk("tmo_hold_seq", 32'(seq), 32'h0821);
    chk("tmo_hold_latency", 32'(toff), 32'd5);
    chk("tmo_hold_set_wins", 32'(tfirst), 32'b0010);
    chk("tmo_hold_cleared", 32'(timeout_err), 32'd0);

    // sticky flag survives idle cycles, err_clr removes it
    clear_errs();
    run_frame(4'b0010, 2, 1, 1'b0, 1'b0, n, seq, bam, toff, tfirst, ok);
    chk("tmo_single_done", 32'(ok), 32'd1);
    repeat (3) step();
    chk("tmo_sticky", 32'(timeout_err), 32'b0010);
    clear_errs();
    chk("tmo_err_clr", 32'(timeout_err), 32'd0);

    // divider reload during a slow frame
    clear_errs();
    run_frame(4'b1111, 3, -1, 1'b0, 1'b1, n, seq, bam, toff, tfirst, ok);
    chk("load_frame_done", 32'(ok), 32'd1);
    chk("load_frame_count", 32'(n), 32'd4);
    chk("load_frame_seq", 32'(seq), 32'h8421);
    chk("load_frame_overrun", 32'(overrun), 32'd1);
    wait_tick(n, ok);
    wait_tick(n, ok);
    chk("load_new_period", 32'(n), 32'd4);

    clear_errs();
    for (int i = 0; i < 5; i++) begin
      cfg_div  = dv[i].div;
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      wait_tick(n, ok);
      chk($sformatf("div%0d_tick_seen", i), 32'(ok), 32'd1);
      step();
      chk($sformatf("div%0d_busy", i), 32'(busy), 32'd1);
      step();
      chk($sformatf("div%0d_mix_latency", i), 32'(mix_en), 32'd1);
      chk($sformatf("div%0d_no_voice_en", i), 32'(voice_en), 32'd0);
      p = 2;
      if (!sample_tick) begin
        wait_tick(k, ok2);
        p += k;
      end
      chk($sformatf("div%0d_period", i), 32'(p), 32'(dv[i].period));
    end
    chk("div_table_no_overrun", 32'(overrun), 32'd0);

    // reset while waiting on a voice
    voice_active = 4'b0001;
    k = 0;
    while (voice_en == 4'd0 && k < 60) begin
      step();
      k++;
    end
    chk("rstwait_reached", 32'(voice_en), 32'b0001);
    rst = 1'b1;
    step();
    chk("rstwait_busy", 32'(busy), 32'd0);
    chk("rstwait_outputs", 32'({sample_tick, voice_en, mix_en, overrun, timeout_err}), 32'd0);
    rst = 1'b0;
    voice_active = '0;
    n = 0; mixes = 0; ok = 1'b0;
    while (!ok && n < 100) begin
      step();
      n++;
      if (mix_en) mixes++;
      if (sample_tick) ok = 1'b1;
    end
    chk("rstwait_first_tick", 32'(n), 32'd10);
    chk("rstwait_no_mix", 32'(mixes), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
